approx_mult_error_scanner: RTL and testbench

- Self-contained hardware error-characterisation engine for approximate multipliers.
- On `start`, sweeps every operand pair of a WIDTH x WIDTH multiplier under test (MUT), one pair per cycle.
- Compares each MUT result against an internally computed exact product and accumulates integer error statistics.
- Sits beside any approximate multiplier in the design; lets error metrics be read in silicon/FPGA instead of only in simulation.

---
 rtl/approx_mult_error_scanner_if.sv | 35 +++
 rtl/approx_mult_error_scanner.sv | 209 ++++++++++++++++++++
 tb/tb_approx_mult_error_scanner.sv | 363 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/approx_mult_error_scanner_if.sv
// Bus between the error scanner and its environment.
// The scanner (slave) drives operands to the multiplier under test and publishes
// the sweep status and error statistics. The environment (master) drives
// start/abort and returns the multiplier product on mut_result.
//   start, abort : sweep control
//   op_a, op_b   : operands presented to the multiplier under test
//   mut_result   : multiplier product, MUT_LATENCY cycles after its operands
//   busy, done   : sweep in progress / one-cycle completion pulse
//   err_count, sum_ed, max_ed, worst_a, worst_b : accumulated error statistics
interface approx_mult_error_scanner_if #(
  parameter int unsigned WIDTH = 4
);
  logic                 start;
  logic                 abort;
  logic [WIDTH-1:0]     op_a;
  logic [WIDTH-1:0]     op_b;
  logic [2*WIDTH-1:0]   mut_result;
  logic                 busy;
  logic                 done;
  logic [2*WIDTH:0]     err_count;
  logic [4*WIDTH:0]     sum_ed;
  logic [2*WIDTH-1:0]   max_ed;
  logic [WIDTH-1:0]     worst_a;
  logic [WIDTH-1:0]     worst_b;

  modport master (
    output start, abort, mut_result,
    input  op_a, op_b, busy, done, err_count, sum_ed, max_ed, worst_a, worst_b
  );

  modport slave (
    input  start, abort, mut_result,
    output op_a, op_b, busy, done, err_count, sum_ed, max_ed, worst_a, worst_b
  );
endinterface

// File: rtl/approx_mult_error_scanner.sv
// Error-characterisation engine for an approximate multiplier.
// On start, sweeps every (a, b) operand pair (a outer, b inner), one pair per
// cycle, compares the multiplier result against the exact product delayed to
// match the multiplier latency, and accumulates error count, sum of absolute
// error distance, maximum error distance and the first pair reaching it.
//   clk : rising-edge clock
//   rst : synchronous active-high reset
//   bus : scanner side of approx_mult_error_scanner_if (see interface header)
module approx_mult_error_scanner #(
  parameter int unsigned WIDTH       = 4,
  parameter int unsigned MUT_LATENCY = 0
) (
  input  logic                      clk,
  input  logic                      rst,
  approx_mult_error_scanner_if.slave bus
);

  localparam int unsigned PW = 2 * WIDTH;      // product / sweep index width
  localparam int unsigned EW = 2 * WIDTH + 1;  // error distance and error count width
  localparam int unsigned SW = 4 * WIDTH + 1;  // error-distance sum width
  localparam int unsigned CW = 4;              // drain counter width
  localparam logic [CW-1:0] DRAIN_INIT =
    CW'((MUT_LATENCY == 32'd0) ? 32'd0 : MUT_LATENCY - 32'd1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SWEEP = 2'd1,
    S_DRAIN = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [PW-1:0]   idx_q, idx_d;
  logic [CW-1:0]   drain_q, drain_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic [EW-1:0]   err_q, err_d;
  logic [SW-1:0]   sum_q, sum_d;
  logic [PW-1:0]   max_q, max_d;
  logic [WIDTH-1:0] wa_q, wa_d;
  logic [WIDTH-1:0] wb_q, wb_d;
  logic            clear_c;

  logic            cmp_valid_c;
  logic [WIDTH-1:0] cmp_a_c;
  logic [WIDTH-1:0] cmp_b_c;
  logic [PW-1:0]   cmp_exact_c;
  logic [PW-1:0]   exact_c;
  logic [EW-1:0]   mut_x_c;
  logic [EW-1:0]   exact_x_c;
  logic [EW-1:0]   ed_c;

  // Exact product of the pair currently driven to the multiplier
  assign exact_c = PW'(idx_q[PW-1:WIDTH]) * PW'(idx_q[WIDTH-1:0]);

  // Align the exact product and operands with the multiplier latency
  if (MUT_LATENCY == 0) begin : g_comb
    assign cmp_valid_c = (state_q == S_SWEEP);
    assign cmp_a_c     = idx_q[PW-1:WIDTH];
    assign cmp_b_c     = idx_q[WIDTH-1:0];
    assign cmp_exact_c = exact_c;
  end else begin : g_pipe
    logic [MUT_LATENCY-1:0] vld_q;
    logic [WIDTH-1:0]       a_q [MUT_LATENCY];
    logic [WIDTH-1:0]       b_q [MUT_LATENCY];
    logic [PW-1:0]          p_q [MUT_LATENCY];

    // Abort discards everything still in flight
    always_ff @(posedge clk) begin
      if (rst || ((state_q != S_IDLE) && bus.abort)) begin
        vld_q <= '0;
      end else begin
        vld_q[0] <= (state_q == S_SWEEP);
        for (int unsigned i = 1; i < MUT_LATENCY; i++) begin
          vld_q[i] <= vld_q[i-1];
        end
      end
    end

    always_ff @(posedge clk) begin
      a_q[0] <= idx_q[PW-1:WIDTH];
      b_q[0] <= idx_q[WIDTH-1:0];
      p_q[0] <= exact_c;
      for (int unsigned i = 1; i < MUT_LATENCY; i++) begin
        a_q[i] <= a_q[i-1];
        b_q[i] <= b_q[i-1];
        p_q[i] <= p_q[i-1];
      end
    end

    assign cmp_valid_c = vld_q[MUT_LATENCY-1];
    assign cmp_a_c     = a_q[MUT_LATENCY-1];
    assign cmp_b_c     = b_q[MUT_LATENCY-1];
    assign cmp_exact_c = p_q[MUT_LATENCY-1];
  end

  // Absolute error distance, one bit wider so the subtraction never wraps
  assign mut_x_c   = {1'b0, bus.mut_result};
  assign exact_x_c = {1'b0, cmp_exact_c};
  assign ed_c      = (mut_x_c >= exact_x_c) ? (mut_x_c - exact_x_c) : (exact_x_c - mut_x_c);

  // Sweep control: next state, index, drain countdown, busy/done
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    drain_d = drain_q;
    done_d  = 1'b0;
    clear_c = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          clear_c = 1'b1;
          idx_d   = '0;
          state_d = S_SWEEP;
        end
      end
      S_SWEEP: begin
        if (bus.abort) begin
          state_d = S_IDLE;
        end else if (idx_q == '1) begin
          if (MUT_LATENCY == 0) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end else begin
            state_d = S_DRAIN;
            drain_d = DRAIN_INIT;
          end
        end else begin
          idx_d = idx_q + PW'(1);
        end
      end
      S_DRAIN: begin
        if (bus.abort) begin
          state_d = S_IDLE;
        end else if (drain_q == '0) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end else begin
          drain_d = drain_q - CW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  // Statistics: cleared on start, updated on every aligned compare
  always_comb begin
    err_d = err_q;
    sum_d = sum_q;
    max_d = max_q;
    wa_d  = wa_q;
    wb_d  = wb_q;
    if (clear_c) begin
      err_d = '0;
      sum_d = '0;
      max_d = '0;
      wa_d  = '0;
      wb_d  = '0;
    end else if (cmp_valid_c) begin
      if (ed_c != '0) begin
        err_d = err_q + EW'(1);
      end
      sum_d = sum_q + SW'(ed_c);
      // Strictly greater: ties keep the earlier pair
      if (ed_c > EW'(max_q)) begin
        max_d = ed_c[PW-1:0];
        wa_d  = cmp_a_c;
        wb_d  = cmp_b_c;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      drain_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= '0;
      sum_q   <= '0;
      max_q   <= '0;
      wa_q    <= '0;
      wb_q    <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      drain_q <= drain_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      sum_q   <= sum_d;
      max_q   <= max_d;
      wa_q    <= wa_d;
      wb_q    <= wb_d;
    end
  end

  assign bus.op_a      = idx_q[PW-1:WIDTH];
  assign bus.op_b      = idx_q[WIDTH-1:0];
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.err_count = err_q;
  assign bus.sum_ed    = sum_q;
  assign bus.max_ed    = max_q;
  assign bus.worst_a   = wa_q;
  assign bus.worst_b   = wb_q;

endmodule

// File: tb/tb_approx_mult_error_scanner.sv
// Bench for approx_mult_error_scanner: three scanner instances with different
// widths/latencies, each beside a small multiplier model. Expected statistics
// come from a reference sweep in the bench, queued at start and compared when
// the sweep finishes, aborts or is reset.
module tb_approx_mult_error_scanner;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  typedef struct {
    int err;
    int sum;
    int max;
    int wa;
    int wb;
  } stats_t;

  stats_t sb_q[$];
  int     checks = 0;
  int     errors = 0;
  int     sel    = 0;
  int     mode0  = 0;
  logic   st [3];
  logic   ab [3];

  approx_mult_error_scanner_if #(.WIDTH(4)) if0 ();
  approx_mult_error_scanner_if #(.WIDTH(4)) if1 ();
  approx_mult_error_scanner_if #(.WIDTH(2)) if2 ();

  approx_mult_error_scanner #(.WIDTH(4), .MUT_LATENCY(0)) u0 (.clk(clk), .rst(rst), .bus(if0));
  approx_mult_error_scanner #(.WIDTH(4), .MUT_LATENCY(3)) u1 (.clk(clk), .rst(rst), .bus(if1));
  approx_mult_error_scanner #(.WIDTH(2), .MUT_LATENCY(1)) u2 (.clk(clk), .rst(rst), .bus(if2));

  assign if0.start = st[0];
  assign if0.abort = ab[0];
  assign if1.start = st[1];
  assign if1.abort = ab[1];
  assign if2.start = st[2];
  assign if2.abort = ab[2];

  // u0: combinational, exact (mode 0) or product with bit 0 forced low (mode 1)
  logic [7:0] p0;
  assign p0 = 8'(if0.op_a) * 8'(if0.op_b);
  assign if0.mut_result = (mode0 == 1) ? (p0 & 8'hFE) : p0;

  // u1: three-stage registered multiplier that always returns zero
  logic [7:0] m1 [3];
  always @(posedge clk) begin
    m1[0] <= 8'd0;
    m1[1] <= m1[0];
    m1[2] <= m1[1];
  end
  assign if1.mut_result = m1[2];

  // u2: one-stage registered a*b+1 saturating at 15
  logic [4:0] p2;
  logic [3:0] m2;
  assign p2 = 5'(4'(if2.op_a) * 4'(if2.op_b)) + 5'd1;
  always @(posedge clk) m2 <= (p2 > 5'd15) ? 4'd15 : p2[3:0];
  assign if2.mut_result = m2;

  // Observed outputs of the selected instance
  logic o_busy, o_done;
  int   o_err, o_sum, o_max, o_wa, o_wb, o_op;
  always_comb begin
    o_busy = if0.busy;
    o_done = if0.done;
    o_err  = 32'(if0.err_count);
    o_sum  = 32'(if0.sum_ed);
    o_max  = 32'(if0.max_ed);
    o_wa   = 32'(if0.worst_a);
    o_wb   = 32'(if0.worst_b);
    o_op   = 32'({if0.op_a, if0.op_b});
    if (sel == 1) begin
      o_busy = if1.busy;
      o_done = if1.done;
      o_err  = 32'(if1.err_count);
      o_sum  = 32'(if1.sum_ed);
      o_max  = 32'(if1.max_ed);
      o_wa   = 32'(if1.worst_a);
      o_wb   = 32'(if1.worst_b);
      o_op   = 32'({if1.op_a, if1.op_b});
    end else if (sel == 2) begin
      o_busy = if2.busy;
      o_done = if2.done;
      o_err  = 32'(if2.err_count);
      o_sum  = 32'(if2.sum_ed);
      o_max  = 32'(if2.max_ed);
      o_wa   = 32'(if2.worst_a);
      o_wb   = 32'(if2.worst_b);
      o_op   = 32'({if2.op_a, if2.op_b});
    end
  end

  // Reference sweep over the first npairs pairs. kind: 0 exact, 1 bit0 cleared,
  // 2 constant zero, 3 a*b+1 saturating at 2^(2w)-1
  function automatic stats_t model(input int kind, input int w, input int npairs);
    stats_t s = '{0, 0, 0, 0, 0};
    int a, b, ex, m, ed;
    int mask = (1 << w) - 1;
    int pmax = (1 << (2 * w)) - 1;
    for (int i = 0; i < npairs; i++) begin
      a  = i >> w;
      b  = i & mask;
      ex = a * b;
      case (kind)
        0:       m = ex;
        1:       m = ex & ~1;
        2:       m = 0;
        default: m = (ex + 1 > pmax) ? pmax : ex + 1;
      endcase
      ed = (m >= ex) ? m - ex : ex - m;
      if (ed != 0) s.err++;
      s.sum += ed;
      if (ed > s.max) begin
        s.max = ed;
        s.wa  = a;
        s.wb  = b;
      end
    end
    return s;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Start a sweep on instance s and watch it for budget cycles.
  // restart_at / abort_at: cycle (1 = first busy cycle) in which start / abort is
  // pulsed, 0 for none. abort_with_start raises abort together with start.
  task automatic run_sweep(input string name, input int s, input int w, input int lat,
                           input int kind, input int restart_at, input int abort_at,
                           input bit abort_with_start, input int budget);
    int     n, npairs, done_c, ndone, busy_n, exp_i;
    logic   busy_after;
    stats_t e;
    n          = 1 << (2 * w);
    npairs     = (abort_at > 0) ? abort_at - lat : n;
    done_c     = -1;
    ndone      = 0;
    busy_n     = 0;
    busy_after = 1'bx;
    sel        = s;
    sb_q.push_back(model(kind, w, npairs));
    st[s] = 1'b1;
    ab[s] = abort_with_start;
    tick();
    for (int c = 1; c <= budget; c++) begin
      st[s] = (c == restart_at);
      ab[s] = (c == abort_at);
      if (o_done === 1'b1) begin
        ndone++;
        if (done_c < 0) done_c = c;
      end
      if (o_busy === 1'b1) busy_n++;
      if (abort_at > 0 && c == abort_at + 1) busy_after = o_busy;
      if (abort_at == 0 && c <= n + lat) begin
        exp_i = (c - 1 < n - 1) ? c - 1 : n - 1;
        checks++;
        if (o_op !== exp_i) begin
          errors++;
          $display("FAIL %s operands cycle %0d: got %0d expected %0d", name, c, o_op, exp_i);
        end
      end
      tick();
    end
    st[s] = 1'b0;
    ab[s] = 1'b0;

    if (abort_at == 0) begin
      checks++;
      if (done_c !== n + lat + 1) begin
        errors++;
        $display("FAIL %s done_cycle: got %0d expected %0d", name, done_c, n + lat + 1);
      end
      checks++;
      if (ndone !== 1) begin
        errors++;
        $display("FAIL %s done_pulses: got %0d expected 1", name, ndone);
      end
      checks++;
      if (busy_n !== n + lat) begin
        errors++;
        $display("FAIL %s busy_cycles: got %0d expected %0d", name, busy_n, n + lat);
      end
    end else begin
      checks++;
      if (ndone !== 0) begin
        errors++;
        $display("FAIL %s done_pulses: got %0d expected 0", name, ndone);
      end
      checks++;
      if (busy_after !== 1'b0) begin
        errors++;
        $display("FAIL %s busy_after_abort: got %b expected 0", name, busy_after);
      end
      checks++;
      if (busy_n !== abort_at) begin
        errors++;
        $display("FAIL %s busy_cycles: got %0d expected %0d", name, busy_n, abort_at);
      end
    end

    e = sb_q.pop_front();
    checks++;
    if (o_err !== e.err) begin
      errors++;
      $display("FAIL %s err_count: got %0d expected %0d", name, o_err, e.err);
    end
    checks++;
    if (o_sum !== e.sum) begin
      errors++;
      $display("FAIL %s sum_ed: got %0d expected %0d", name, o_sum, e.sum);
    end
    checks++;
    if (o_max !== e.max) begin
      errors++;
      $display("FAIL %s max_ed: got %0d expected %0d", name, o_max, e.max);
    end
    checks++;
    if (o_wa !== e.wa) begin
      errors++;
      $display("FAIL %s worst_a: got %0d expected %0d", name, o_wa, e.wa);
    end
    checks++;
    if (o_wb !== e.wb) begin
      errors++;
      $display("FAIL %s worst_b: got %0d expected %0d", name, o_wb, e.wb);
    end
  endtask

  // All outputs of the selected instance must read zero / idle
  task automatic check_cleared(input string name);
    checks++;
    if (o_busy !== 1'b0) begin
      errors++;
      $display("FAIL %s busy: got %b expected 0", name, o_busy);
    end
    checks++;
    if (o_done !== 1'b0) begin
      errors++;
      $display("FAIL %s done: got %b expected 0", name, o_done);
    end
    checks++;
    if (o_op !== 0) begin
      errors++;
      $display("FAIL %s operands: got %0d expected 0", name, o_op);
    end
    checks++;
    if (o_err !== 0 || o_sum !== 0 || o_max !== 0) begin
      errors++;
      $display("FAIL %s stats: got err=%0d sum=%0d max=%0d expected 0", name, o_err, o_sum, o_max);
    end
    checks++;
    if (o_wa !== 0 || o_wb !== 0) begin
      errors++;
      $display("FAIL %s worst_pair: got %0d,%0d expected 0,0", name, o_wa, o_wb);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (4) tick();
    for (int s = 0; s < 3; s++) begin
      sel = s;
      #1;
      check_cleared($sformatf("reset_u%0d", s));
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_bit0_mut();
    mode0 = 1;
    run_sweep("bit0_w4_l0", 0, 4, 0, 1, 0, 0, 1'b0, 260);
  endtask

  task automatic test_exact_mut();
    mode0 = 0;
    run_sweep("exact_w4_l0", 0, 4, 0, 0, 0, 0, 1'b0, 260);
  endtask

  task automatic test_start_ignored();
    mode0 = 0;
    run_sweep("restart_ignored", 0, 4, 0, 0, 50, 0, 1'b0, 260);
  endtask

  task automatic test_latency3();
    run_sweep("zero_w4_l3", 1, 4, 3, 2, 0, 0, 1'b0, 263);
  endtask

  task automatic test_width2();
    run_sweep("plus1_w2_l1", 2, 2, 1, 3, 0, 0, 1'b0, 21);
  endtask

  // Second start lands on the first cycle after done, with abort also high
  task automatic test_back_to_back();
    mode0 = 1;
    run_sweep("b2b_first", 0, 4, 0, 1, 0, 0, 1'b0, 257);
    mode0 = 0;
    run_sweep("b2b_second", 0, 4, 0, 0, 0, 0, 1'b1, 260);
  endtask

  task automatic test_abort();
    mode0 = 1;
    run_sweep("abort_mid", 0, 4, 0, 1, 0, 25, 1'b0, 60);
  endtask

  task automatic test_rst_mid_sweep();
    stats_t e;
    int     ndone = 0;
    int     nbusy = 0;
    sel   = 0;
    mode0 = 1;
    sb_q.push_back(model(1, 4, 39));
    st[0] = 1'b1;
    tick();
    st[0] = 1'b0;
    repeat (39) tick();
    e = sb_q.pop_front();
    checks++;
    if (o_err !== e.err || o_sum !== e.sum) begin
      errors++;
      $display("FAIL rst_mid partial_stats: got err=%0d sum=%0d expected err=%0d sum=%0d",
               o_err, o_sum, e.err, e.sum);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_cleared("rst_mid");
    for (int c = 0; c < 300; c++) begin
      if (o_done === 1'b1) ndone++;
      if (o_busy === 1'b1) nbusy++;
      tick();
    end
    checks++;
    if (ndone !== 0 || nbusy !== 0) begin
      errors++;
      $display("FAIL rst_mid after_reset: got done=%0d busy=%0d cycles expected 0", ndone, nbusy);
    end
  endtask

  initial begin
    for (int s = 0; s < 3; s++) begin
      st[s] = 1'b0;
      ab[s] = 1'b0;
    end
    test_reset();
    test_bit0_mut();
    test_exact_mut();
    test_start_ignored();
    test_latency3();
    test_width2();
    test_back_to_back();
    test_abort();
    test_rst_mid_sweep();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
